// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the HI/LO result path: fixed-latency multiply,
// XLEN-cycle restoring divide, decoder stall and exception flush.
module md_unit_ctrl #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hilo_rd,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            hilo_we,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  localparam int CNT_MAX = (MUL_CYCLES > XLEN) ? MUL_CYCLES - 1 : XLEN - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   rem_q, quo_q;

  logic              accept, finish;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              a_neg, b_neg, ge;
  logic [XLEN-1:0]   a_mag, dvs, r_sub, rem_nx, quo_nx, quo_fix, rem_fix;
  logic [XLEN:0]     r_shift;

  assign accept  = (state == IDLE) && start && !flush;
  assign finish  = ((state == MUL) || (state == DIV)) && (cnt == '0) && !flush;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign hilo_we = done && !flush;
  assign stall   = busy && (start || hilo_rd);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = op[1] ? DIV : MUL;
      MUL,
      DIV:     if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Sign-extending to 2*XLEN makes the truncated product correct for MULT too.
  assign mul_a = {{XLEN{op_q[0] & a_q[XLEN-1]}}, a_q};
  assign mul_b = {{XLEN{op_q[0] & b_q[XLEN-1]}}, b_q};
  assign prod  = mul_a * mul_b;

  assign a_mag   = (op[0] && a[XLEN-1]) ? -a : a;
  assign a_neg   = op_q[0] & a_q[XLEN-1];
  assign b_neg   = op_q[0] & b_q[XLEN-1];
  assign dvs     = b_neg ? -b_q : b_q;
  assign r_shift = {rem_q, quo_q[XLEN-1]};
  assign ge      = (r_shift >= {1'b0, dvs});
  // The true difference is below dvs, so XLEN-bit modular subtraction is exact.
  assign r_sub   = r_shift[XLEN-1:0] - dvs;
  assign rem_nx  = ge ? r_sub : r_shift[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], ge};
  assign quo_fix = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
  assign rem_fix = a_neg ? -rem_nx : rem_nx;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too, so nothing depends on power-up values.
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        cnt   <= op[1] ? DIV_INIT : MUL_INIT;
        rem_q <= '0;
        quo_q <= a_mag;
      end else if (((state == MUL) || (state == DIV)) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
        if (state == DIV) begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
        end
      end

      // The last divide iteration and its sign fix land directly in HI/LO.
      if (finish) begin
        if (state == MUL) begin
          hi_out <= prod[2*XLEN-1:XLEN];
          lo_out <= prod[XLEN-1:0];
        end else if (b_q == '0) begin
          hi_out <= a_q;
          lo_out <= '1;
        end else begin
          hi_out <= rem_fix;
          lo_out <= quo_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Randomised self-checking bench for md_unit_ctrl against an arithmetic
// reference model of HI/LO results and cycle latency.
module tb_md_unit_ctrl;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 3;

  logic            clk = 1'b0;
  logic            rst, start, flush, hilo_rd;
  logic [1:0]      op;
  logic [XLEN-1:0] a, b;
  logic            stall, busy, done, hilo_we;
  logic [XLEN-1:0] hi_out, lo_out;

  int n_cmp = 0;
  int n_err = 0;

  md_unit_ctrl #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hilo_rd(hilo_rd), .stall(stall), .busy(busy),
    .done(done), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: p = {32'd0, x} * {32'd0, y};
      2'd1: p = sx * sy;
      2'd2: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
    return o[1] ? XLEN : MUL_CYCLES;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op from IDLE (called #1 after an edge); returns at the done sample.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, y, input bit fl,
                       output int lat, output logic [31:0] hi, lo,
                       output logic we, dn, output bit busy_ok);
    busy_ok = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = c; break; end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (fl) begin flush = 1'b1; #1; end
    hi = hi_out; lo = lo_out; we = hilo_we; dn = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; hilo_rd = 1'b1; flush = 1'b0;
    op = 2'd0; a = '0; b = '0;
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, hilo_we, stall} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: busy/done/we/stall=%b want 0000", {busy, done, hilo_we, stall});
    end
    n_cmp++;
    if ({hi_out, lo_out} !== 64'd0) begin
      n_err++; $display("FAIL reset_hilo: got %h_%h want 0", hi_out, lo_out);
    end
    rst = 1'b0; start = 1'b0; hilo_rd = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0};
    logic [31:0] t_a  [6] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] t_b  [6] = '{32'd5, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'h9ABC_DEF0};
    logic [63:0] t_exp[6] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0002_0000_000E,
                              64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0005_FFFF_FFFF,
                              64'h0000_0000_8000_0000, 64'h0B00_EA4E_242D_2080};
    int lat; logic [31:0] hi, lo; logic we, dn; bit bok;
    for (int i = 0; i < 6; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 1'b0, lat, hi, lo, we, dn, bok);
      n_cmp++;
      if (lat !== exp_lat(t_op[i]) || !bok) begin
        n_err++; $display("FAIL dir%0d_latency: lat=%0d busy_ok=%0d want %0d/1", i, lat, bok, exp_lat(t_op[i]));
      end
      n_cmp++;
      if ({hi, lo} !== t_exp[i] || we !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_result: hi_lo=%h we=%b want %h we=1", i, {hi, lo}, we, t_exp[i]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, hilo_we} !== 3'b0) begin
        n_err++; $display("FAIL dir%0d_done_once: busy/done/we=%b want 000", i, {busy, done, hilo_we});
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] hi, lo, x, y; logic [1:0] o; logic we, dn; bit bok;
    logic [63:0] e;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = rnd_opnd();
      y = rnd_opnd();
      e = model(o, x, y);
      do_op(o, x, y, 1'b0, lat, hi, lo, we, dn, bok);
      n_cmp++;
      if (lat !== exp_lat(o) || !bok || we !== 1'b1) begin
        n_err++; $display("FAIL rnd%0d_timing: op=%0d lat=%0d busy_ok=%0d we=%b want %0d/1/1", i, o, lat, bok, we, exp_lat(o));
      end
      n_cmp++;
      if ({hi, lo} !== e) begin
        n_err++; $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h want %h", i, o, x, y, {hi, lo}, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [31:0] dx, dy, mx, my;
    logic [63:0] de, me;
    int lat, lat2; bit stall_bad;
    dx = 32'($urandom); dy = 32'($urandom_range(1, 1000));
    mx = 32'($urandom); my = 32'($urandom);
    de = model(2'd2, dx, dy);
    me = model(2'd0, mx, my);
    start = 1'b1; op = 2'd2; a = dx; b = dy;
    @(posedge clk); #1;
    start = 1'b0;
    stall_bad = 1'b0; lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c >= 5 && stall !== 1'b1) stall_bad = 1'b1;
      if (c < 5 && stall !== 1'b0) stall_bad = 1'b1;
      if (done === 1'b1) begin lat = c; break; end
      if (c == 4) begin hilo_rd = 1'b1; start = 1'b1; op = 2'd0; a = mx; b = my; end
    end
    n_cmp++;
    if (lat !== XLEN || stall_bad) begin
      n_err++; $display("FAIL stall_div: lat=%0d stall_bad=%0d want %0d/0", lat, stall_bad, XLEN);
    end
    n_cmp++;
    if ({hi_out, lo_out} !== de) begin
      n_err++; $display("FAIL stall_div_result: got %h want %h", {hi_out, lo_out}, de);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, stall} !== 2'b00) begin
      n_err++; $display("FAIL stall_gap: busy/stall=%b want 00", {busy, stall});
    end
    @(posedge clk); #1;
    start = 1'b0; hilo_rd = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL stall_held_accept: busy=%b want 1", busy); end
    lat2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat2 = c; break; end
    end
    n_cmp++;
    if (lat2 !== MUL_CYCLES || {hi_out, lo_out} !== me) begin
      n_err++; $display("FAIL stall_mul: lat=%0d hi_lo=%h want %0d %h", lat2, {hi_out, lo_out}, MUL_CYCLES, me);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int lat; logic [31:0] hi, lo, x, y; logic we, dn; bit bok, bad;
    logic [63:0] prev, e;
    x = 32'($urandom) | 32'h1; y = 32'($urandom) | 32'h1;
    do_op(2'd0, x, y, 1'b0, lat, hi, lo, we, dn, bok);
    @(posedge clk); #1;
    prev = {hi_out, lo_out};
    // Flush in the 10th DIV cycle.
    start = 1'b1; op = 2'd3; a = 32'($urandom); b = 32'($urandom_range(1, 99));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if ({busy, done, hilo_we} !== 3'b0) begin
      n_err++; $display("FAIL flush_div: busy/done/we=%b want 000", {busy, done, hilo_we});
    end
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || {hi_out, lo_out} !== prev) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL flush_hold: hi_lo=%h want %h, no done", {hi_out, lo_out}, prev); end
    // Flush together with start in IDLE.
    flush = 1'b1; start = 1'b1; op = 2'd1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_start: busy=%b want 0", busy); end
    // Flush in the DONE cycle.
    x = 32'($urandom); y = 32'($urandom);
    e = model(2'd1, x, y);
    do_op(2'd1, x, y, 1'b1, lat, hi, lo, we, dn, bok);
    n_cmp++;
    if (dn !== 1'b1 || we !== 1'b0 || {hi, lo} !== e) begin
      n_err++; $display("FAIL flush_done: done=%b we=%b hi_lo=%h want 1 0 %h", dn, we, {hi, lo}, e);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || {hi_out, lo_out} !== e) begin
      n_err++; $display("FAIL flush_done_keep: busy=%b hi_lo=%h want 0 %h", busy, {hi_out, lo_out}, e);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] hi, lo; logic we, dn; bit bok;
    do_op(2'd0, 32'd7, 32'd9, 1'b0, lat, hi, lo, we, dn, bok);
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; a = 32'($urandom); b = 32'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, hilo_we, stall} !== 4'b0 || {hi_out, lo_out} !== 64'd0) begin
      n_err++; $display("FAIL reset_mid: ctrl=%b hi_lo=%h want 0000 0", {busy, done, hilo_we, stall}, {hi_out, lo_out});
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || {hi_out, lo_out} !== 64'd0) begin
      n_err++; $display("FAIL reset_mid_nowrite: done=%b hi_lo=%h want 0 0", done, {hi_out, lo_out});
    end
    do_op(2'd0, 32'd2, 32'd3, 1'b0, lat, hi, lo, we, dn, bok);
    n_cmp++;
    if (lat !== MUL_CYCLES || hi !== 32'd0 || lo !== 32'd6) begin
      n_err++; $display("FAIL reset_mid_mul: lat=%0d hi=%h lo=%h want %0d 0 6", lat, hi, lo, MUL_CYCLES);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
